uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter on the CPU data-memory/IO bus, decoded in the IO page (0x1000–0x10FF). The CPU writes bytes into a small TX FIFO. A bit-timing FSM serialises them as 8N1 frames on the tx pin. When the FIFO drains, the block raises a level interrupt that feeds one of the CPU interrupt inputs; the matching CPU clear strobe drops it.

---
 rtl/uart_tx_pkg.sv | 37 +++
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/uart_tx_periph.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets relative to the block base address
//   - bit positions inside the STATUS and CTRL registers
//   - encoding of the bit-timing FSM states
package uart_tx_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIV_LO = 3'd3;
    localparam logic [2:0] REG_DIV_HI = 3'd4;

    // Highest offset the block decodes
    localparam logic [15:0] REG_LAST_OFFSET = 16'd4;

    // STATUS register bit positions
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_IRQ   = 3;
    localparam int STAT_OVF   = 4;

    // CTRL register bit positions
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Bit-timing FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } txState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO holding bytes waiting to be serialised.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset, empties the FIFO
//   push_i      write request; accepted when not full, or when full and
//               a pop happens in the same cycle
//   pushData_i  data written on an accepted push
//   pop_i       read request; ignored when empty
//   popData_o   head entry (valid whenever empty_o is low)
//   full_o      all DEPTH entries occupied
//   empty_o     no entries occupied
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pushOk;
    logic             popOk;

    assign empty_o   = (wrPtr_q == rdPtr_q);
    assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popData_o = mem_q[rdPtr_q[AW-1:0]];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign popOk  = pop_i && !empty_o;
    assign pushOk = push_i && (!full_o || popOk);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter living in the CPU IO page.
// The CPU writes bytes into a TX FIFO; an FSM shifts them out LSB first.
// When the transmitter drains, a level interrupt is raised.
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous active-low reset
//   address   bus address; block decodes BASE_ADDR..BASE_ADDR+4
//   din       bus write data
//   write_en  single-cycle write strobe
//   read_en   read strobe
//   dout      registered read data, 0 when not selected
//   irq       level interrupt (irq_pend & irq_en)
//   irq_clr   interrupt clear pulse from the CPU
//   tx        serial output, idle high
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h1010,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  din,
    input  logic        write_en,
    input  logic        read_en,
    output logic [7:0]  dout,
    output logic        irq,
    input  logic        irq_clr,
    output logic        tx
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [15:0] offsetFull;
    logic [2:0]  regOff;
    logic        hit;
    logic        wrHit;
    logic        rdHit;

    // Addresses below the base wrap to large offsets, so one unsigned
    // compare covers both ends of the window.
    assign offsetFull = address - BASE_ADDR;
    assign hit        = (offsetFull <= REG_LAST_OFFSET);
    assign regOff     = offsetFull[2:0];
    assign wrHit      = write_en && hit;
    assign rdHit      = read_en && hit;

    // ------------------------------------------------------------------
    // Registers and FSM state
    // ------------------------------------------------------------------
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic        irqPend_q, irqPend_d;
    logic [7:0]  dout_q, dout_d;

    txState_e    state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;

    logic        txEn;
    logic        irqEn;
    logic        periodEnd;
    logic        frameDone;
    logic        irqSet;

    logic        pushReq;
    logic        fifoPop;
    logic [7:0]  fifoData;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [7:0]  statusVal;
    logic [7:0]  readData;

    assign txEn      = ctrl_q[CTRL_TX_EN];
    assign irqEn     = ctrl_q[CTRL_IRQ_EN];
    assign pushReq   = wrHit && (regOff == REG_DATA);
    assign periodEnd = (cnt_q == period_q);
    assign irqSet    = frameDone && fifoEmpty;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .push_i     (pushReq),
        .pushData_i (din),
        .pop_i      (fifoPop),
        .popData_o  (fifoData),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // ------------------------------------------------------------------
    // Bit-timing FSM: next state
    // ------------------------------------------------------------------
    // Each state lasts period_q+1 cycles; the divisor is captured at pop
    // time so a mid-frame DIV write only affects the following frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        fifoPop   = 1'b0;
        frameDone = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                bitIdx_d = '0;
                if (txEn && !fifoEmpty) begin
                    fifoPop  = 1'b1;
                    shift_d  = fifoData;
                    period_d = div_q;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (periodEnd) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (periodEnd) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (periodEnd) begin
                    cnt_d     = '0;
                    frameDone = 1'b1;
                    // Chain straight into the next frame with no idle gap.
                    if (txEn && !fifoEmpty) begin
                        fifoPop  = 1'b1;
                        shift_d  = fifoData;
                        period_d = div_q;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial output decoded from state so an async reset forces it high.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Register writes, W1C and hardware status updates
    // ------------------------------------------------------------------
    // Hardware sets are applied last so they win over software clears.
    always_comb begin
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        ovf_d     = ovf_q;
        irqPend_d = irqPend_q;

        if (wrHit) begin
            case (regOff)
                REG_STATUS: begin
                    if (din[STAT_IRQ]) begin
                        irqPend_d = 1'b0;
                    end
                    if (din[STAT_OVF]) begin
                        ovf_d = 1'b0;
                    end
                end
                REG_CTRL:   ctrl_d      = din[1:0];
                REG_DIV_LO: div_d[7:0]  = din;
                REG_DIV_HI: div_d[15:8] = din;
                default:    ;
            endcase
        end

        if (irq_clr) begin
            irqPend_d = 1'b0;
        end

        if (pushReq && fifoFull && !fifoPop) begin
            ovf_d = 1'b1;
        end

        if (irqSet) begin
            irqPend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path: one-cycle latency, zero when not selected
    // ------------------------------------------------------------------
    always_comb begin
        statusVal             = '0;
        statusVal[STAT_EMPTY] = fifoEmpty;
        statusVal[STAT_FULL]  = fifoFull;
        statusVal[STAT_BUSY]  = (state_q != ST_IDLE);
        statusVal[STAT_IRQ]   = irqPend_q;
        statusVal[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        readData = '0;
        case (regOff)
            REG_STATUS: readData = statusVal;
            REG_CTRL:   readData = {6'b0, ctrl_q};
            REG_DIV_LO: readData = div_q[7:0];
            REG_DIV_HI: readData = div_q[15:8];
            default:    readData = '0;
        endcase
        dout_d = rdHit ? readData : 8'h00;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            div_q     <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            irqPend_q <= 1'b0;
            dout_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            irqPend_q <= irqPend_d;
            dout_q    <= dout_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irqPend_q & irqEn;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph
// Directed testbench for uart_tx_periph: drives bus reads/writes and
// compares the tx waveform, dout and irq against hand-computed values.
module tb_uart_tx_periph;

    localparam logic [15:0] BASE     = 16'h1010;
    localparam logic [15:0] A_DATA   = BASE + 16'd0;
    localparam logic [15:0] A_STATUS = BASE + 16'd1;
    localparam logic [15:0] A_CTRL   = BASE + 16'd2;
    localparam logic [15:0] A_DIVLO  = BASE + 16'd3;
    localparam logic [15:0] A_DIVHI  = BASE + 16'd4;

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  din;
    logic        write_en;
    logic        read_en;
    logic [7:0]  dout;
    logic        irq;
    logic        irq_clr;
    logic        tx;

    int checkCount;
    int errorCount;
    int irqHighCycles;

    logic [7:0] rdNow;
    logic [7:0] rdNext;

    uart_tx_periph #(
        .BASE_ADDR   (16'h1010),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd103)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .din      (din),
        .write_en (write_en),
        .read_en  (read_en),
        .dout     (dout),
        .irq      (irq),
        .irq_clr  (irq_clr),
        .tx       (tx)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bus write cycle
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        address  = addr;
        din      = data;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    // One bus read: returns dout in the cycle after read_en and the one after
    task automatic busRead(input logic [15:0] addr, output logic [7:0] dNow,
                           output logic [7:0] dNext);
        @(negedge clk);
        address = addr;
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        dNow    = dout;
        @(negedge clk);
        dNext   = dout;
    endtask

    // Poll on falling edges until the start bit appears, bounded by budget
    task automatic waitStart(input string tag, input int budget);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " start seen"}, {15'd0, tx === 1'b0}, 16'd1);
    endtask

    // Check one full 8N1 frame starting at the current (first start-bit) cycle
    task automatic checkFrame(input string tag, input logic [7:0] dataByte,
                              input int period);
        int  bad;
        logic expBit;
        bad = 0;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      expBit = 1'b0;
            else if (b == 9) expBit = 1'b1;
            else             expBit = dataByte[b-1];
            for (int c = 0; c < period; c++) begin
                if (tx !== expBit) bad++;
                if (irq === 1'b1) irqHighCycles++;
                @(negedge clk);
            end
        end
        checkOutput(tag, bad[15:0], 16'd0);
    endtask

    function automatic logic [7:0] byteFor(input int i);
        return 8'(i * 37 + 11);
    endfunction

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        irqHighCycles = 0;
        reset    = 1'b0;
        address  = '0;
        din      = '0;
        write_en = 1'b0;
        read_en  = 1'b0;
        irq_clr  = 1'b0;

        // Reset state
        #1;
        checkOutput("reset tx", {15'd0, tx}, 16'd1);
        checkOutput("reset dout", {8'd0, dout}, 16'd0);
        checkOutput("reset irq", {15'd0, irq}, 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("reset status", {8'd0, rdNow}, 16'h0001);
        busRead(A_DIVLO, rdNow, rdNext);
        checkOutput("reset div_lo", {8'd0, rdNow}, 16'd103);

        // Test 1: DIV=3, tx_en only, single byte 0xA5
        $display("[TB] single frame DIV=3");
        applyStimulus(A_DIVLO, 8'h03);
        applyStimulus(A_DIVHI, 8'h00);
        applyStimulus(A_CTRL, 8'h01);
        fork
            applyStimulus(A_DATA, 8'hA5);
            begin
                waitStart("t1", 20);
                checkFrame("t1 frame A5", 8'hA5, 4);
            end
            begin
                repeat (8) @(negedge clk);
                busRead(A_STATUS, rdNow, rdNext);
                checkOutput("t1 status busy", {8'd0, rdNow}, 16'h0005);
            end
        join
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t1 status drained", {8'd0, rdNow}, 16'h0009);
        checkOutput("t1 irq gated", {15'd0, irq}, 16'd0);

        // Test 2: DIV=0, irq enabled, three back-to-back frames
        $display("[TB] back-to-back frames DIV=0");
        applyStimulus(A_STATUS, 8'h08);
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t2 w1c irq", {8'd0, rdNow}, 16'h0001);
        applyStimulus(A_DIVLO, 8'h00);
        applyStimulus(A_CTRL, 8'h03);
        irqHighCycles = 0;
        fork
            begin
                applyStimulus(A_DATA, 8'h3C);
                applyStimulus(A_DATA, 8'h81);
                applyStimulus(A_DATA, 8'hFF);
            end
            begin
                waitStart("t2", 20);
                checkFrame("t2 frame 3C", 8'h3C, 1);
                checkFrame("t2 frame 81", 8'h81, 1);
                checkFrame("t2 frame FF", 8'hFF, 1);
            end
        join
        checkOutput("t2 irq low during frames", irqHighCycles[15:0], 16'd0);
        checkOutput("t2 irq after drain", {15'd0, irq}, 16'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        checkOutput("t2 irq after clr", {15'd0, irq}, 16'd0);

        // Test 3: overflow with tx disabled, then drain 8 frames
        $display("[TB] fifo overflow");
        applyStimulus(A_CTRL, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(A_DATA, byteFor(i));
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t3 status full ovf", {8'd0, rdNow}, 16'h0012);
        applyStimulus(A_STATUS, 8'h10);
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t3 status after w1c", {8'd0, rdNow}, 16'h0002);
        fork
            applyStimulus(A_CTRL, 8'h01);
            begin
                waitStart("t3", 20);
                for (int i = 0; i < 8; i++)
                    checkFrame($sformatf("t3 frame %0d", i), byteFor(i), 1);
            end
        join
        begin
            int lowCycles;
            lowCycles = 0;
            for (int c = 0; c < 20; c++) begin
                if (tx !== 1'b1) lowCycles++;
                @(negedge clk);
            end
            checkOutput("t3 idle after 8 frames", lowCycles[15:0], 16'd0);
        end

        // Test 4: read latency and unmapped addresses
        $display("[TB] read path");
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t4 status read", {8'd0, rdNow}, 16'h0009);
        checkOutput("t4 status next cycle", {8'd0, rdNext}, 16'h0000);
        checkOutput("t4 irq gated", {15'd0, irq}, 16'd0);
        busRead(A_CTRL, rdNow, rdNext);
        checkOutput("t4 ctrl read", {8'd0, rdNow}, 16'h0001);
        busRead(A_DATA, rdNow, rdNext);
        checkOutput("t4 data read", {8'd0, rdNow}, 16'h0000);
        busRead(BASE + 16'd5, rdNow, rdNext);
        checkOutput("t4 unmapped +5", {8'd0, rdNow}, 16'h0000);
        checkOutput("t4 unmapped +5 next", {8'd0, rdNext}, 16'h0000);
        busRead(BASE - 16'd1, rdNow, rdNext);
        checkOutput("t4 unmapped -1", {8'd0, rdNow}, 16'h0000);

        // Test 5: DIV change mid-frame applies to the next frame only
        $display("[TB] divisor change mid-frame");
        applyStimulus(A_DIVLO, 8'h01);
        fork
            begin
                applyStimulus(A_DATA, 8'hC3);
                applyStimulus(A_DATA, 8'h5A);
                repeat (3) @(negedge clk);
                applyStimulus(A_DIVLO, 8'h07);
            end
            begin
                waitStart("t5", 20);
                checkFrame("t5 frame div1", 8'hC3, 2);
                checkFrame("t5 frame div7", 8'h5A, 8);
            end
        join

        // Test 6: asynchronous reset in the middle of DATA
        $display("[TB] reset mid-frame");
        applyStimulus(A_CTRL, 8'h03);
        checkOutput("t6 irq before reset", {15'd0, irq}, 16'd1);
        applyStimulus(A_DIVLO, 8'h03);
        applyStimulus(A_DATA, 8'h00);
        waitStart("t6", 20);
        repeat (6) @(negedge clk);
        checkOutput("t6 tx in data bit", {15'd0, tx}, 16'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6 tx async reset", {15'd0, tx}, 16'd1);
        checkOutput("t6 irq async reset", {15'd0, irq}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        busRead(A_STATUS, rdNow, rdNext);
        checkOutput("t6 status after reset", {8'd0, rdNow}, 16'h0001);
        busRead(A_DIVLO, rdNow, rdNext);
        checkOutput("t6 div_lo after reset", {8'd0, rdNow}, 16'h0067);
        busRead(A_DIVHI, rdNow, rdNext);
        checkOutput("t6 div_hi after reset", {8'd0, rdNow}, 16'h0000);
        busRead(A_CTRL, rdNow, rdNext);
        checkOutput("t6 ctrl after reset", {8'd0, rdNow}, 16'h0000);
        checkOutput("t6 tx idle after reset", {15'd0, tx}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errorCount++;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
